multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main control FSM of the multicycle RV32I core. Sequences the shared ALU through fetch/decode/execute/writeback,
//  drives its 4-bit select and operand muxes, gates all architectural write enables and resolves branches from ALU zero.
//  Sits between instruction register (opcode/funct fields) and datapath; stalls on a single memory ready handshake.
// PARAMETERS
//  RESET_TRAP   0   1: illegal opcode parks FSM in TRAP until reset; 0: illegal opcode treated as NOP (back to FETCH)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high; clears state immediately
//  opcode       in   7   instr[6:0] from instruction register
//  funct3       in   3   instr[14:12]
//  funct7b5     in   1   instr[30]
//  zero         in   1   ALU zero flag (aluOut==0), combinational from ALU
//  mem_ready    in   1   memory completes current access this cycle
//  alu_select   out  4   0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 SLL,8 SRL,9 SRA
//  alu_src_a    out  2   00 PC, 01 oldPC, 10 rs1 reg
//  alu_src_b    out  2   00 rs2 reg, 01 imm, 10 const 4
//  result_src   out  2   00 ALUOut reg, 01 mem data reg, 10 ALU result, 11 imm (LUI)
//  adr_src      out  1   0 PC, 1 result
//  mem_req      out  1   memory access requested (held until mem_ready)
//  ir_write     out  1   latch instruction / oldPC
//  pc_write     out  1   PC <= result (unconditional update or taken branch)
//  reg_write    out  1   rd <= result
//  mem_write    out  1   store strobe
//  illegal      out  1   sticky, opcode not RV32I base set (TRAP state)
// BEHAVIOUR
//  - Reset: state=FETCH; while reset high all write enables, mem_req, illegal =0; alu_select=ADD, srcs=00.
//  - Outputs Moore-decoded from state except pc_write in BRANCH (Mealy on zero) and mem handshake gating.
//  - FETCH: mem_req=1, adr_src=0, ADD PC+4 (src_a=00,src_b=10,result_src=10). Hold until mem_ready; on ready
//    ir_write=1, pc_write=1, ->DECODE. No write enable pulses while waiting.
//  - DECODE: ADD oldPC+imm (branch target into ALUOut). Next by opcode: 0000011/0100011 ->MEMADR; 0110011 ->EXECR;
//    0010011 ->EXECI; 1100011 ->BRANCH; 1101111 ->JAL; 1100111 ->JALR; 0110111 ->LUI; 0010111 ->AUIPC; else ->TRAP
//    (RESET_TRAP=1) or FETCH.
//  - MEMADR: ADD rs1+imm; load ->MEMREAD, store ->MEMWRITE.
//  - MEMREAD: mem_req, adr_src=1; wait mem_ready ->MEMWB. MEMWB: result_src=01, reg_write ->FETCH.
//  - MEMWRITE: mem_req, adr_src=1, mem_write held high; on mem_ready ->FETCH.
//  - EXECR: rs1 op rs2; funct3 000 ADD/SUB(funct7b5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA(funct7b5),
//    110 OR, 111 AND. EXECI: same with src_b=imm; funct3 000 always ADD (funct7b5 ignored). Both ->ALUWB.
//  - ALUWB: result_src=00, reg_write ->FETCH.
//  - BRANCH: rs1 vs rs2, result_src=00 (target). BEQ/BNE SUB, BLT/BGE SLT, BLTU/BGEU SLTU. Taken: BEQ zero;
//    BNE,BLT,BLTU !zero; BGE,BGEU zero. pc_write=taken, same cycle. Reserved funct3 010/011: not taken. ->FETCH.
//  - JAL: pc_write (target from ALUOut); ALU ADD oldPC+4 ->ALUWB. JALR: ADD rs1+imm, pc_write next via ALUWB-like
//    JALWB sub-step: JALR ->JALR2 (pc_write from ALUOut, ALU oldPC+4) ->ALUWB. LUI: result_src=11, reg_write ->FETCH.
//    AUIPC: ADD oldPC+imm ->ALUWB.
//  - TRAP: illegal=1, all enables 0; exits only by reset.
//  - rd=x0 suppression is the register file's job, not this block's.
//  - Reset mid-access: state returns to FETCH asynchronously; a pending mem_req drops the same instant.
//  - CPI: R/I/AUIPC/JAL 4, LUI 3, branch 3, JALR 5, load 5, store 4 (+ wait cycles).
// STRUCTURE
//  - Shared package riscv_defs: ALU_* select codes, OP_* opcodes, mux encodings, state encoding (4-bit).
//  - Sub-module alu_op_decoder (combinational: state-class, funct3, funct7b5 -> alu_select); rest is state reg +
//    next-state/output logic.
// TESTING
//  - Reset asserted mid-MEMREAD with mem_ready=0 -> state FETCH, mem_req/reg_write=0 same cycle, illegal=0.
//  - FETCH with mem_ready low 3 cycles -> ir_write/pc_write stay 0; asserted on 4th cycle only, once.
//  - R-type opcode 0110011 funct3=101 funct7b5=1 -> EXECR alu_select=9 (SRA), ALUWB reg_write=1, total 4 cycles.
//  - BLT funct3=100, zero=0 in BRANCH -> alu_select=5, pc_write=1; zero=1 -> pc_write=0.
//  - Store 0100011 -> MEMADR ADD src_b=01, MEMWRITE mem_write=1 held through 2 wait cycles, then FETCH.
//  - Opcode 1111111 with RESET_TRAP=1 -> TRAP, illegal=1 sticky, no enables until reset; RESET_TRAP=0 -> FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// ============================================================================
//  Module   : riscv_defs (package)
//  Purpose  : Shared encodings for the multicycle RV32I control path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_defs;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;
    localparam logic [1:0] RES_IMM     = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        ALU_CLS_ADD    = 2'd0,
        ALU_CLS_RTYPE  = 2'd1,
        ALU_CLS_ITYPE  = 2'd2,
        ALU_CLS_BRANCH = 2'd3
    } alu_cls_t;

    // Branch outcome from the ALU zero flag; SLT/SLTU yield 1 (nonzero) when "less".
    function automatic logic branch_taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return !z;
            3'b101:  return z;
            3'b110:  return !z;
            3'b111:  return z;
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_alu_op_decoder.sv
// ============================================================================
//  Module   : alu_op_decoder
//  Purpose  : Maps operation class + funct fields onto the 4-bit ALU select.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_decoder
    import riscv_defs::*;
(
    input  logic [1:0] alu_cls,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_select
);

    always_comb begin
        alu_select = ALU_ADD;
        case (alu_cls)
            ALU_CLS_RTYPE, ALU_CLS_ITYPE: begin
                case (funct3)
                    // Immediate forms have no SUB; bit 30 is part of the immediate there.
                    3'b000: alu_select = (alu_cls == ALU_CLS_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_select = ALU_SLL;
                    3'b010: alu_select = ALU_SLT;
                    3'b011: alu_select = ALU_SLTU;
                    3'b100: alu_select = ALU_XOR;
                    3'b101: alu_select = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_select = ALU_OR;
                    3'b111: alu_select = ALU_AND;
                endcase
            end
            ALU_CLS_BRANCH: begin
                case (funct3[2:1])
                    2'b10:   alu_select = ALU_SLT;
                    2'b11:   alu_select = ALU_SLTU;
                    default: alu_select = ALU_SUB;
                endcase
            end
            default: alu_select = ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
// ============================================================================
//  Module   : multicycle_ctrl_fsm
//  Purpose  : Main control FSM of the multicycle RV32I core.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_fsm
    import riscv_defs::*;
#(
    parameter logic RESET_TRAP = 1'b0
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_select,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       mem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       illegal
);

    state_t   r_state;
    state_t   w_next;
    alu_cls_t w_alu_cls;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_alu_cls  = ALU_CLS_ADD;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        adr_src    = 1'b0;
        mem_req    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    OP_AUIPC:          w_next = S_AUIPC;
                    default:           w_next = RESET_TRAP ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                w_next    = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                w_alu_cls = ALU_CLS_RTYPE;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                w_alu_cls = ALU_CLS_ITYPE;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                // ALUOut still holds the target computed in DECODE.
                alu_src_a = SRCA_RS1;
                w_alu_cls = ALU_CLS_BRANCH;
                pc_write  = branch_taken(funct3, zero);
                w_next    = S_FETCH;
            end
            S_JAL, S_JALR2: begin
                pc_write  = 1'b1;
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                w_next    = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                w_next    = S_JALR2;
            end
            S_LUI: begin
                result_src = RES_IMM;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                w_next    = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset is asynchronous, so outputs are silenced directly rather than via state.
        if (reset) begin
            w_alu_cls  = ALU_CLS_ADD;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_RS2;
            result_src = RES_ALUOUT;
            adr_src    = 1'b0;
            mem_req    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            illegal    = 1'b0;
        end
    end

    alu_op_decoder u_alu_op_decoder (
        .alu_cls    (w_alu_cls),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .alu_select (alu_select)
    );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
// ============================================================================
//  Module   : tb_multicycle_ctrl_fsm
//  Purpose  : Instruction-level reference model bench for both RESET_TRAP builds.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic [3:0] alu;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic       adr;
        logic       req;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic       ill;
    } outs_t;

    localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_BR = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;

    logic [3:0] alu_select [2];
    logic [1:0] alu_src_a [2], alu_src_b [2], result_src [2];
    logic       adr_src [2], mem_req [2], ir_write [2], pc_write [2];
    logic       reg_write [2], mem_write [2], illegal [2];

    int  n_vec = 0, n_err = 0;
    int  m_step [2];
    bit  m_trap [2];
    int  alu_base [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.RESET_TRAP(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .alu_select(alu_select[0]), .alu_src_a(alu_src_a[0]),
        .alu_src_b(alu_src_b[0]), .result_src(result_src[0]), .adr_src(adr_src[0]),
        .mem_req(mem_req[0]), .ir_write(ir_write[0]), .pc_write(pc_write[0]),
        .reg_write(reg_write[0]), .mem_write(mem_write[0]), .illegal(illegal[0])
    );

    multicycle_ctrl_fsm #(.RESET_TRAP(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .alu_select(alu_select[1]), .alu_src_a(alu_src_a[1]),
        .alu_src_b(alu_src_b[1]), .result_src(result_src[1]), .adr_src(adr_src[1]),
        .mem_req(mem_req[1]), .ir_write(ir_write[1]), .pc_write(pc_write[1]),
        .reg_write(reg_write[1]), .mem_write(mem_write[1]), .illegal(illegal[1])
    );

    function automatic int kind_of(input logic [6:0] op);
        for (int i = 0; i < 9; i++) if (op == legal_ops[i]) return i;
        return K_ILL;
    endfunction

    function automatic int cpi_of(input int k);
        case (k)
            K_LOAD, K_JALR:                 return 5;
            K_STORE, K_R, K_I, K_JAL, K_AUIPC: return 4;
            K_BR, K_LUI:                    return 3;
            default:                        return 2;
        endcase
    endfunction

    // Step 0 is fetch, step 1 decode, steps 2.. the instruction-specific tail.
    function automatic outs_t model_outs(input int k, input int step, input logic [2:0] f3,
                                         input logic f7, input logic z, input logic rdy,
                                         input bit trapped);
        outs_t o;
        o = '0;
        if (trapped) begin
            o.ill = 1'b1;
            return o;
        end
        if (step == 0) begin
            o.req = 1'b1; o.sb = 2'd2; o.rs = 2'd2; o.irw = rdy; o.pcw = rdy;
        end else if (step == 1) begin
            o.sa = 2'd1; o.sb = 2'd1;
        end else begin
            case (k)
                K_LOAD, K_STORE: begin
                    if (step == 2) begin o.sa = 2'd2; o.sb = 2'd1; end
                    else if (step == 3) begin o.req = 1'b1; o.adr = 1'b1; o.mw = (k == K_STORE); end
                    else begin o.rs = 2'd1; o.rw = 1'b1; end
                end
                K_R, K_I: begin
                    if (step == 2) begin
                        o.sa  = 2'd2;
                        o.sb  = (k == K_I) ? 2'd1 : 2'd0;
                        o.alu = 4'(alu_base[f3] + int'((f3 == 3'd0 && k == K_R && f7) || (f3 == 3'd5 && f7)));
                    end else o.rw = 1'b1;
                end
                K_BR: begin
                    o.sa  = 2'd2;
                    o.alu = !f3[2] ? 4'd1 : (f3[1] ? 4'd6 : 4'd5);
                    o.pcw = (f3[2:1] != 2'b01) && (z ^ f3[0] ^ f3[2]);
                end
                K_JAL: begin
                    if (step == 2) begin o.pcw = 1'b1; o.sa = 2'd1; o.sb = 2'd2; end
                    else o.rw = 1'b1;
                end
                K_JALR: begin
                    if (step == 2) begin o.sa = 2'd2; o.sb = 2'd1; end
                    else if (step == 3) begin o.pcw = 1'b1; o.sa = 2'd1; o.sb = 2'd2; end
                    else o.rw = 1'b1;
                end
                K_LUI: begin o.rs = 2'd3; o.rw = 1'b1; end
                K_AUIPC: begin
                    if (step == 2) begin o.sa = 2'd1; o.sb = 2'd1; end
                    else o.rw = 1'b1;
                end
                default: ;
            endcase
        end
        return o;
    endfunction

    function automatic outs_t act_of(input int d);
        return {alu_select[d], alu_src_a[d], alu_src_b[d], result_src[d], adr_src[d],
                mem_req[d], ir_write[d], pc_write[d], reg_write[d], mem_write[d], illegal[d]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    // Per-cycle compare against the model, then advance the model across the coming edge.
    initial begin
        outs_t e, a;
        int    k;
        bit    waiting;
        m_step = '{0, 0};
        m_trap = '{0, 0};
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                k = kind_of(opcode);
                e = reset ? '0 : model_outs(k, m_step[d], funct3, funct7b5, zero, mem_ready, m_trap[d]);
                a = act_of(d);
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL outputs dut%0d step%0d op=%b: got %h want %h",
                             d, m_step[d], opcode, a, e);
                end
                if (reset) begin
                    m_step[d] = 0;
                    m_trap[d] = 1'b0;
                end else if (!m_trap[d]) begin
                    waiting = (m_step[d] == 0 || (m_step[d] == 3 && (k == K_LOAD || k == K_STORE)))
                              && !mem_ready;
                    if (!waiting) begin
                        if (k == K_ILL && m_step[d] == 1 && d == 1) begin
                            m_trap[d] = 1'b1;
                            m_step[d] = 0;
                        end else begin
                            m_step[d] = (m_step[d] + 1 >= cpi_of(k)) ? 0 : m_step[d] + 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        at_neg();
        check("rst_mem_req", 32'(mem_req[0]), 0);
        check("rst_alu", 32'(alu_select[0]), 0);
        check("rst_illegal", 32'(illegal[1]), 0);

        // R-type SRA with a three-cycle fetch stall
        tick(); reset = 1'b0; opcode = 7'b0110011; funct3 = 3'd5; funct7b5 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            at_neg();
            check("fetch_wait_irw", 32'(ir_write[0]), 0);
            check("fetch_wait_pcw", 32'(pc_write[0]), 0);
        end
        tick(); mem_ready = 1'b1;
        at_neg();
        check("fetch_irw", 32'(ir_write[0]), 1);
        check("fetch_pcw", 32'(pc_write[0]), 1);
        tick(); mem_ready = 1'b0;
        tick(); at_neg();
        check("sra_alu", 32'(alu_select[0]), 9);
        tick(); at_neg();
        check("aluwb_rw", 32'(reg_write[0]), 1);
        tick(); at_neg();
        check("r_done_req", 32'(mem_req[0]), 1);
        check("r_done_irw", 32'(ir_write[0]), 0);

        // BLT: Mealy pc_write on zero
        tick(); opcode = 7'b1100011; funct3 = 3'd4; funct7b5 = 1'b0; mem_ready = 1'b1;
        tick(); mem_ready = 1'b0;
        tick(); zero = 1'b0;
        at_neg();
        check("blt_alu", 32'(alu_select[0]), 5);
        check("blt_taken", 32'(pc_write[0]), 1);
        zero = 1'b1; #1;
        check("blt_not_taken", 32'(pc_write[0]), 0);

        // Store with two memory wait cycles
        tick(); opcode = 7'b0100011; funct3 = 3'd2; zero = 1'b0; mem_ready = 1'b1;
        tick(); mem_ready = 1'b0;
        tick(); at_neg();
        check("memadr_alu", 32'(alu_select[0]), 0);
        check("memadr_srcb", 32'(alu_src_b[0]), 1);
        for (int i = 0; i < 2; i++) begin
            tick(); at_neg();
            check("store_wait_mw", 32'(mem_write[0]), 1);
        end
        tick(); mem_ready = 1'b1;
        at_neg();
        check("store_done_mw", 32'(mem_write[0]), 1);
        tick(); mem_ready = 1'b0;
        at_neg();
        check("store_fetch_mw", 32'(mem_write[0]), 0);
        check("store_fetch_req", 32'(mem_req[0]), 1);

        // Illegal opcode: TRAP build parks, NOP build refetches
        tick(); opcode = 7'b1111111; mem_ready = 1'b1;
        tick(); mem_ready = 1'b0;
        tick(); at_neg();
        check("trap_ill1", 32'(illegal[1]), 1);
        check("trap_req1", 32'(mem_req[1]), 0);
        check("nop_ill0", 32'(illegal[0]), 0);
        check("nop_req0", 32'(mem_req[0]), 1);

        // Load, then reset while MEMREAD waits
        tick(); opcode = 7'b0000011; funct3 = 3'd2; mem_ready = 1'b1;
        tick(); mem_ready = 1'b0;
        tick();
        tick(); at_neg();
        check("memread_req", 32'(mem_req[0]), 1);
        check("memread_adr", 32'(adr_src[0]), 1);
        check("trap_sticky", 32'(illegal[1]), 1);
        reset = 1'b1; #1;
        check("async_rst_req", 32'(mem_req[0]), 0);
        check("async_rst_rw", 32'(reg_write[0]), 0);
        check("async_rst_ill1", 32'(illegal[1]), 0);
        tick(); tick(); reset = 1'b0;
        at_neg();
        check("post_rst_req0", 32'(mem_req[0]), 1);
        check("post_rst_req1", 32'(mem_req[1]), 1);

        // Randomized instruction stream with occasional resets
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 59) == 0) reset = 1'b1;
            if (m_step[0] == 0) begin
                int idx;
                idx = $urandom_range(0, 9);
                opcode   = (idx < 9) ? legal_ops[idx] : 7'($urandom);
                funct3   = 3'($urandom);
                funct7b5 = 1'($urandom);
            end
            mem_ready = ($urandom_range(0, 2) != 0);
            zero      = 1'($urandom);
        end
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
